// File: rtl/ep_serial_tx_if.sv
// ep_serial_tx_if: parallel word handshake into the serial transmitter.
// The master offers din/din_valid and the transmitter answers with din_ready.
interface ep_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/ep_serial_tx.sv
// ep_serial_tx: even-parity serial frame transmitter.
// Idle-high line; frame = start, data LSB first, parity, stop.
module ep_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ep_serial_tx_if.slave link,
    output logic          txd,
    output logic          busy,
    output logic          par
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic [DATA_W-1:0] shift, shift_n, shift_nx;
    logic              par_n, txd_n, busy_n;
    logic              rdy, rdy_n, bit_end;

    assign link.din_ready = rdy;
    assign bit_end        = (cnt == CNT_LAST);
    assign shift_nx       = shift >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            par   <= 1'b0;
            txd   <= 1'b1;
            busy  <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            par   <= par_n;
            txd   <= txd_n;
            busy  <= busy_n;
            rdy   <= rdy_n;
        end
    end

    // Outputs are computed for the state being entered, so the
    // registered txd/busy/din_ready line up with the new state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        par_n   = par;
        txd_n   = 1'b1;
        busy_n  = 1'b1;
        rdy_n   = 1'b0;
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                rdy_n  = 1'b1;
                if (link.din_valid && rdy) begin
                    shift_n = link.din;
                    par_n   = ^link.din;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = START;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                    rdy_n   = 1'b0;
                end
            end
            START: begin
                txd_n = 1'b0;
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                    txd_n   = shift[0];
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                txd_n = shift[0];
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shift_nx;
                    idx_n   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_n = PARITY;
                        txd_n   = par;
                    end else begin
                        txd_n = shift_nx[0];
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PARITY: begin
                txd_n = par;
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    txd_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                txd_n = 1'b1;
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    rdy_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule
